pe_psum_accum: RTL and testbench
================================

# pe_psum_accum

Downstream stage of the PE sign-magnitude pair adder. Consumes its two's-complement partial sums, one per cycle, under a valid/ready handshake and accumulates them over a group delimited by a last flag. Each finished group is presented as a saturated signed result with overflow and beat-count sideband. One instance per PE column sits between the adder chain and the PE output FIFO.

## Interface
Parameters:
- IN_W, 6, width of the adder's two's-complement output (adder SIZE + 2).
- ACC_W, 16, accumulator and result width, signed; must be greater than IN_W.
- CNT_W, 8, beat-counter width; maximum group length 2^CNT_W − 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; discards the partial group.
- in_valid  in  1  partial sum present.
- in_ready  out  1  stage accepts a beat.
- in_data  in  IN_W  signed partial sum from the adder.
- in_last  in  1  beat closes the group.
- out_valid  out  1  group result held.
- out_ready  in  1  consumer takes the result.
- out_data  out  ACC_W  signed saturated group sum.
- out_ovf  out  1  saturation occurred anywhere in the group.
- out_cnt  out  CNT_W  beats in the group, including the last beat.

## Operation
- Accept: a beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready.
- Sign extension: in_data is sign-extended to ACC_W.
- Saturating add: acc_next = sat(acc + sext(in_data)).
  - Positive overflow clamps to 2^(ACC_W−1)−1; negative overflow clamps to −2^(ACC_W−1).
  - Any clamp sets a sticky ovf for the group.
- Beat count: cnt increments per accepted beat and saturates at all-ones. Saturation of the count also sets ovf.
- State machine, two states:
  - IDLE: acc=0, cnt=0, ovf=0.
  - ACCUM: entered on the first accepted beat without in_last.
  - Accepted beat with in_last, from either state: the final sum, count and ovf are loaded into the output register and out_valid is set. The accumulator returns to IDLE (acc=0, cnt=0, ovf=0).
  - A single-beat group (in_last on the first beat) goes IDLE → IDLE.
- Output register: holds out_data, out_ovf and out_cnt stable while out_valid && !out_ready. It clears out_valid on out_ready when no new last-beat arrives that cycle.
- Simultaneous events:
  - out_ready and an accepted last beat in the same cycle: the register reloads with the new result and out_valid stays 1.
  - A non-last beat accepted while the output drains: it accumulates normally.
- clear:
  - Forces acc, cnt and ovf to zero and the state to IDLE.
  - Any beat presented that cycle is dropped, but in_ready is unaffected.
  - A pending output is not cleared.
- Reset (asynchronous, any time): all state to IDLE; out_valid=0, out_data=0, out_ovf=0, out_cnt=0. in_ready=1 once reset is deasserted. A mid-group reset loses the group.

## Timing
- Latency: result visible on out_valid one cycle after the accepted last beat.
- Throughput: one beat per cycle sustained while out_ready=1, including back-to-back single-beat groups.
- in_ready is combinational from out_valid/out_ready only, with no dependency on in_valid.
- No combinational path from in_* to out_*.
- Reset values: in_ready=1 (after deassertion), out_valid=0, out_data=0, out_ovf=0, out_cnt=0.

## Structure
- Shared package pe_accum_pkg holds:
  - the state enum {IDLE, ACCUM};
  - the default ACC_W and CNT_W values;
  - functions for the signed max/min saturation constants of a given width.
- Sub-module pe_sat_add (parameterised width):
  - inputs: sign-extended operand and accumulator;
  - outputs: clamped sum and overflow flag;
  - purely combinational, reused by later column reducers.
- The top level holds the FSM, counter, sticky flag and output register.

## Test plan
- Group of four beats {+5, −3, +31, −32}, in_last on the 4th, out_ready=1 → one cycle later out_valid=1, out_data=1, out_cnt=4, out_ovf=0.
- ACC_W=8, 5 beats of +31 → out_data=127, out_ovf=1, out_cnt=5. The next group {−2} (single beat) → out_data=−2, out_ovf=0.
- Backpressure:
  - out_ready=0 after a result: in_ready=0 and out_data is held for 10 cycles.
  - Raising out_ready with a waiting last-beat {+7} → the old result is consumed and the new result (7, cnt=1) is loaded in the same cycle; out_valid stays high.
- Back-to-back single-beat groups {1, 2, 3} on consecutive cycles with out_ready=1 → out_valid high for 3 consecutive cycles with out_data 1, 2, 3.
- clear asserted after beats {+10, +10} → the next group {+4, last} yields 4, cnt=1. A pending prior result survives the clear.
- rst_n pulsed low mid-group and mid-output-stall → all outputs 0 immediately. After release, in_ready=1 and a group {−1, last} yields −1, cnt=1.

Source files
------------

// File: rtl/pe_accum_pkg.sv
// Shared types and constants for the PE partial-sum accumulation column.
// Both the accumulator top and the saturating adder import this package.
package pe_accum_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

    localparam int DEF_ACC_W = 16;
    localparam int DEF_CNT_W = 8;

    // Largest and smallest two's-complement values representable in w bits.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational two's-complement adder that clamps to the signed range of W bits.
// Reused by the column accumulator and by later column reducers.
module pe_sat_add
    import pe_accum_pkg::*;
#(
    parameter int W = DEF_ACC_W
) (
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_opd,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);

    localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
    localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));

    logic [W-1:0] w_raw;
    logic         w_pos_ovf;
    logic         w_neg_ovf;

    assign w_raw = i_acc + i_opd;

    // Overflow only when both operands share a sign and the wrapped sum flips it.
    assign w_pos_ovf = !i_acc[W-1] && !i_opd[W-1] &&  w_raw[W-1];
    assign w_neg_ovf =  i_acc[W-1] &&  i_opd[W-1] && !w_raw[W-1];

    always_comb begin
        o_sum = w_raw;
        if (w_pos_ovf) begin
            o_sum = SAT_MAX;
        end else if (w_neg_ovf) begin
            o_sum = SAT_MIN;
        end
    end

    assign o_ovf = w_pos_ovf | w_neg_ovf;

endmodule

// File: rtl/pe_psum_accum.sv
// Column accumulator: sums signed partial sums over a last-delimited group and
// presents each group as a saturated result with overflow and beat-count sideband.
module pe_psum_accum
    import pe_accum_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_cnt,
    output logic [0:0]       dbg_state
);

    localparam logic [0:0] S_IDLE  = ST_IDLE;
    localparam logic [0:0] S_ACCUM = ST_ACCUM;

    if (ACC_W <= IN_W) begin : g_bad_width
        $error("pe_psum_accum: ACC_W must exceed IN_W");
    end

    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic             r_out_ovf;
    logic [CNT_W-1:0] r_out_cnt;

    logic [0:0]       w_state_next;
    logic             w_accept;
    logic             w_close;
    logic [ACC_W-1:0] w_sext;
    logic [ACC_W-1:0] w_sum;
    logic             w_add_ovf;
    logic             w_cnt_sat;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_next;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready,
    // a result transfers where out_valid && out_ready; in_ready depends only on
    // the output register state, and clear drops the beat without touching in_ready.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !clear;
    assign w_close  = w_accept && in_last;

    assign w_sext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

    pe_sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .i_acc (r_acc),
        .i_opd (w_sext),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    // The count holds at all-ones; a beat beyond that marks the group as overflowed.
    assign w_cnt_sat  = &r_cnt;
    assign w_cnt_next = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
    assign w_ovf_next = r_ovf | w_add_ovf | w_cnt_sat;

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = S_IDLE;
        end else if (w_accept) begin
            w_state_next = in_last ? S_IDLE : S_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (clear || w_close) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_next;
                r_ovf <= w_ovf_next;
            end
        end
    end

    // A closing beat reloads the register even while the previous result drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_cnt   <= '0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sum;
            r_out_ovf   <= w_ovf_next;
            r_out_cnt   <= w_cnt_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign out_cnt   = r_out_cnt;
    assign dbg_state = r_state;

    property p_out_hold;
        @(posedge clk) disable iff (!rst_n)
            (r_out_valid && !out_ready) |=>
                (r_out_valid && $stable(r_out_data) && $stable(r_out_ovf) && $stable(r_out_cnt));
    endproperty
    a_out_hold: assert property (p_out_hold);

endmodule

// File: tb/tb_pe_psum_accum.sv
// Bench for pe_psum_accum: one ACC_W=16 and one ACC_W=8 instance share all inputs;
// a reference model fills per-instance expected queues as beats are accepted.
module tb_pe_psum_accum;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic [5:0]        in_data;
    logic              in_last;
    logic              out_ready;

    logic              in_ready16, in_ready8;
    logic              out_valid16, out_valid8;
    logic signed [15:0] out_data16;
    logic signed [7:0]  out_data8;
    logic              out_ovf16, out_ovf8;
    logic [7:0]        out_cnt16, out_cnt8;
    logic [0:0]        dbg16, dbg8;

    logic [24:0] exp_q16[$];
    logic [16:0] exp_q8[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_pop_cyc = -10;
    int streak = 0;

    longint m_acc[2];
    bit     m_ovf[2];
    int     m_cnt;

    pe_psum_accum #(.IN_W(6), .ACC_W(16), .CNT_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
        .out_ovf(out_ovf16), .out_cnt(out_cnt16), .dbg_state(dbg16)
    );

    pe_psum_accum #(.IN_W(6), .ACC_W(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .out_ovf(out_ovf8), .out_cnt(out_cnt8), .dbg_state(dbg8)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model
    task automatic model_clear();
        m_acc[0] = 0; m_acc[1] = 0;
        m_ovf[0] = 0; m_ovf[1] = 0;
        m_cnt = 0;
    endtask

    task automatic model_beat(input logic [5:0] d, input logic last);
        longint s, mx;
        int w;
        for (int k = 0; k < 2; k++) begin
            w  = (k == 0) ? 16 : 8;
            mx = (longint'(1) <<< (w - 1)) - 1;
            s  = m_acc[k] + longint'($signed(d));
            if (s > mx) begin
                s = mx; m_ovf[k] = 1;
            end else if (s < -mx - 1) begin
                s = -mx - 1; m_ovf[k] = 1;
            end
            m_acc[k] = s;
        end
        if (m_cnt == 255) begin
            m_ovf[0] = 1; m_ovf[1] = 1;
        end else begin
            m_cnt++;
        end
        if (last) begin
            exp_q16.push_back({16'(m_acc[0]), m_ovf[0], 8'(m_cnt)});
            exp_q8.push_back({8'(m_acc[1]), m_ovf[1], 8'(m_cnt)});
            model_clear();
        end
    endtask

    // scoreboard: inputs stay stable between posedge+1 and the next posedge
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid16 && out_ready) begin
                if (exp_q16.size() == 0) check_val("sb16_unexpected", 1, 0);
                else check_val("sb16", {out_data16, out_ovf16, out_cnt16}, exp_q16.pop_front());
                streak = (cyc == last_pop_cyc + 1) ? streak + 1 : 1;
                last_pop_cyc = cyc;
            end
            if (out_valid8 && out_ready) begin
                if (exp_q8.size() == 0) check_val("sb8_unexpected", 1, 0);
                else check_val("sb8", {out_data8, out_ovf8, out_cnt8}, exp_q8.pop_front());
            end
            if (clear) model_clear();
            else if (in_valid && in_ready16) model_beat(in_data, in_last);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 6'(d);
        in_last  = last;
        @(negedge clk);
        while (!in_ready16 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check_val("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic flush_model();
        exp_q16.delete();
        exp_q8.delete();
        model_clear();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", out_valid16, 0);
        check_val("rst_out_data", out_data16, 0);
        check_val("rst_out_ovf", out_ovf16, 0);
        check_val("rst_out_cnt", out_cnt16, 0);
        check_val("rst_in_ready", in_ready16, 1);
        check_val("rst_state", dbg16, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // basic group of four
        send(5, 0);
        @(negedge clk);
        check_val("state_accum", dbg16, 1);
        tick();
        send(-3, 0); send(31, 0); send(-32, 1);
        @(negedge clk);
        check_val("g4_valid", out_valid16, 1);
        check_val("g4_data", out_data16, 1);
        check_val("g4_cnt", out_cnt16, 4);
        check_val("g4_ovf", out_ovf16, 0);
        check_val("g4_state_idle", dbg16, 0);
        repeat (3) tick();

        // positive clamp on the narrow instance, then a clean single beat
        for (int i = 0; i < 5; i++) send(31, (i == 4));
        @(negedge clk);
        check_val("pos8_data", out_data8, 127);
        check_val("pos8_ovf", out_ovf8, 1);
        check_val("pos8_cnt", out_cnt8, 5);
        check_val("pos16_data", out_data16, 155);
        check_val("pos16_ovf", out_ovf16, 0);
        tick();
        send(-2, 1);
        @(negedge clk);
        check_val("single8_data", out_data8, -2);
        check_val("single8_ovf", out_ovf8, 0);
        check_val("single16_data", out_data16, -2);
        tick();

        // negative clamp
        for (int i = 0; i < 5; i++) send(-32, (i == 4));
        @(negedge clk);
        check_val("neg8_data", out_data8, -128);
        check_val("neg8_ovf", out_ovf8, 1);
        check_val("neg16_data", out_data16, -160);
        repeat (3) tick();

        // backpressure hold, then drain and reload in the same cycle
        out_ready = 1'b0;
        send(9, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("hold_in_ready", in_ready16, 0);
            check_val("hold_valid", out_valid16, 1);
            check_val("hold_data", out_data16, 9);
        end
        tick();
        in_valid = 1'b1; in_data = 6'd7; in_last = 1'b1;
        @(negedge clk);
        check_val("wait_in_ready", in_ready16, 0);
        tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check_val("reload_valid", out_valid16, 1);
        check_val("reload_data", out_data16, 7);
        check_val("reload_cnt", out_cnt16, 1);
        repeat (3) tick();

        // back-to-back single-beat groups
        send(1, 1); send(2, 1); send(3, 1);
        @(negedge clk);
        #1;
        check_val("b2b_streak", streak, 3);
        check_val("b2b_last_data", out_data16, 3);
        tick();

        // clear mid-group, with a last beat presented in the clear cycle
        send(10, 0); send(10, 0);
        clear = 1'b1; in_valid = 1'b1; in_data = 6'd20; in_last = 1'b1;
        @(negedge clk);
        check_val("clear_in_ready", in_ready16, 1);
        tick();
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check_val("clear_no_output", out_valid16, 0);
        check_val("clear_state", dbg16, 0);
        tick();
        send(4, 1);
        @(negedge clk);
        check_val("after_clear_data", out_data16, 4);
        check_val("after_clear_cnt", out_cnt16, 1);
        tick();

        // clear does not touch a pending result
        out_ready = 1'b0;
        send(3, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        check_val("pend_valid", out_valid16, 1);
        check_val("pend_data", out_data16, 3);
        tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // beat-count saturation
        for (int i = 0; i < 256; i++) send(0, (i == 255));
        @(negedge clk);
        check_val("cnt_sat_cnt", out_cnt16, 255);
        check_val("cnt_sat_ovf", out_ovf16, 1);
        repeat (3) tick();

        // reset during an output stall
        out_ready = 1'b0;
        send(7, 1);
        @(negedge clk);
        check_val("stall_valid", out_valid16, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", out_valid16, 0);
        check_val("arst_data", out_data16, 0);
        check_val("arst_cnt", out_cnt16, 0);
        check_val("arst_ovf", out_ovf16, 0);
        check_val("arst_valid8", out_valid8, 0);
        flush_model();
        out_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", in_ready16, 1);
        tick();

        // reset mid-group loses the partial sum
        send(5, 0); send(6, 0);
        @(negedge clk);
        check_val("midgrp_state", dbg16, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_val("midgrp_rst_state", dbg16, 0);
        flush_model();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send(-1, 1);
        @(negedge clk);
        check_val("post_rst_data", out_data16, -1);
        check_val("post_rst_cnt", out_cnt16, 1);
        check_val("post_rst_ovf", out_ovf16, 0);

        repeat (5) tick();
        check_val("drain_q16", exp_q16.size(), 0);
        check_val("drain_q8", exp_q8.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
